// File: rtl/stream_mux_pkg.sv
// Shared mode encodings and index helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Successor of a channel index in an n-entry ring.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Producer/consumer bundle of the stream multiplexer; slave is the mux side.
interface stream_mux_rr_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx,
  output logic          any_gnt
);

  always_comb begin
    logic [SW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = SW'((int'(ptr) + k) % N);
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with round-robin or fixed selection and a single output register.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_rr_if.slave  bus
);

  logic [SW-1:0] ptr_p0;
  logic [W-1:0]  data_p0;
  logic [SW-1:0] ch_p0;
  logic          vld_p0;

  logic [N-1:0]  rr_gnt;
  logic [SW-1:0] rr_idx;
  logic          rr_any;

  logic          fix_ok;
  logic [N-1:0]  fix_gnt;
  logic [N-1:0]  gnt_vec;
  logic [SW-1:0] gnt_idx;
  logic          gnt_any;
  logic          load;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_p0),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any_gnt (rr_any)
  );

  // Out-of-range sel must never index in_valid, so range check gates the lookup.
  assign fix_ok  = (int'(bus.sel) < N) && bus.in_valid[bus.sel];
  assign fix_gnt = fix_ok ? (N'(1) << bus.sel) : '0;

  always_comb begin
    gnt_vec = rr_gnt;
    gnt_idx = rr_idx;
    gnt_any = rr_any;
    if (bus.mode == MODE_FIXED) begin
      gnt_vec = fix_gnt;
      gnt_idx = bus.sel;
      gnt_any = fix_ok;
    end
  end

  assign load         = !vld_p0 || bus.out_ready;
  assign bus.in_ready = (load && !rst) ? gnt_vec : '0;

  // Stage p0: output word register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ch_p0   <= '0;
      ptr_p0  <= '0;
    end else if (load) begin
      if (gnt_any) begin
        data_p0 <= bus.in_data[int'(gnt_idx)*W +: W];
        ch_p0   <= gnt_idx;
        vld_p0  <= 1'b1;
        if (bus.mode == MODE_RR)
          ptr_p0 <= SW'(wrap_next(int'(gnt_idx), N));
      end else begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_p0;
  assign bus.out_ch    = ch_p0;
  assign bus.out_valid = vld_p0;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with N=4, W=8 and channel data A0+i.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.N(4), .W(8)) bus ();

  stream_mux_rr #(.N(4), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] data, input logic [1:0] ch);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.out_data),  32'(data));
    chk({tag, "_ch"},    32'(bus.out_ch),    32'(ch));
  endtask

  initial begin
    logic [1:0] rr_ch [5];
    logic [1:0] sp_ch [4];
    rr_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    sp_ch = '{2'd3, 2'd0, 2'd3, 2'd0};

    rst           = 1'b1;
    bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.in_valid  = 4'b1111;
    bus.mode      = MODE_RR;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'h00);
    chk("rst_ch",    32'(bus.out_ch),    32'd0);
    chk("rst_ready", 32'(bus.in_ready),  32'b0000);
    rst = 1'b0;
    #1;
    chk("rr_ready0", 32'(bus.in_ready), 32'b0001);

    // Round-robin fairness
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 8'hA0 + 8'(rr_ch[i]), rr_ch[i]);
    end

    // Backpressure holds A0, release yields A1
    bus.out_ready = 1'b0;
    #1;
    chk("bp_ready", 32'(bus.in_ready), 32'b0000);
    tick();
    chk_out("bp_hold0", 8'hA0, 2'd0);
    tick();
    chk_out("bp_hold1", 8'hA0, 2'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    chk_out("bp_next", 8'hA1, 2'd1);

    // Sparse wrap-around from ptr = 1
    bus.in_valid = 4'b0001;
    tick();
    chk_out("sp_setup", 8'hA0, 2'd0);
    bus.in_valid = 4'b1001;
    #1;
    chk("sp_ready", 32'(bus.in_ready), 32'b1000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("sp%0d", i), 8'hA0 + 8'(sp_ch[i]), sp_ch[i]);
    end

    // Fixed mode, sel = 2
    bus.mode     = MODE_FIXED;
    bus.sel      = 2'd2;
    bus.in_valid = 4'b1111;
    #1;
    chk("fx_ready", 32'(bus.in_ready), 32'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("fx%0d", i), 8'hA2, 2'd2);
    end

    // Fixed mode, sel = 3 with channel 3 idle
    bus.sel      = 2'd3;
    bus.in_valid = 4'b0111;
    #1;
    chk("idle_ready", 32'(bus.in_ready), 32'b0000);
    tick();
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_data",  32'(bus.out_data),  32'hA2);
    chk("idle_ch",    32'(bus.out_ch),    32'd2);

    // Mode switch with a held word
    bus.sel       = 2'd2;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    #1;
    chk("ms_fill_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    chk_out("ms_held", 8'hA2, 2'd2);
    bus.mode = MODE_RR;
    #1;
    chk("ms_stall_ready", 32'(bus.in_ready), 32'b0000);
    tick();
    chk_out("ms_still", 8'hA2, 2'd2);
    bus.out_ready = 1'b1;
    #1;
    chk("ms_resume_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    chk_out("ms_resume", 8'hA1, 2'd1);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_data",  32'(bus.out_data),  32'h00);
    chk("arst_ch",    32'(bus.out_ch),    32'd0);
    chk("arst_ready", 32'(bus.in_ready),  32'b0000);
    tick();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes on every input and on the output. It has two modes: round-robin arbitration across requesting channels, or fixed selection by a select input. The selected word is captured in a single output register, which gives a one-cycle forwarding latency and full one-word-per-cycle throughput. The block sits between several producer streams and one shared consumer, and is the next generation of the plain 4-to-1 combinational mux.

## Interface
- N, 4: number of input channels, N ≥ 2; non-power-of-2 values are allowed.
- W, 8: data width per channel.
- SW, $clog2(N): width of the channel index.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit is set in any cycle.
- mode  in  1  0 = round-robin (MODE_RR), 1 = fixed select (MODE_FIXED).
- sel  in  SW  channel index used when mode = 1.
- out_data  out  W  registered output word.
- out_ch  out  SW  index of the channel that supplied out_data.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts the output word.

## Operation
- State consists of the output register (out_data, out_ch, out_valid) and the round-robin pointer ptr [SW-1:0].
- load = !out_valid || out_ready. The register can take a new word when it is empty or is being drained this cycle.
- Grant in round-robin mode: the first i with in_valid[i] = 1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
- Grant in fixed mode: channel sel, if sel < N and in_valid[sel] = 1. Otherwise there is no grant.
- in_ready[g] = load for the granted channel g. All other in_ready bits are 0. With no grant, in_ready = 0.
- Rising edge with load and a grant:
  - out_data ← slice g
  - out_ch ← g
  - out_valid ← 1
  - ptr ← (g == N-1) ? 0 : g+1, in mode 0 only. Mode 1 leaves ptr unchanged.
- Rising edge with load and no grant: out_valid ← 0. out_data and out_ch hold.
- Rising edge without load (out_valid = 1, out_ready = 0): all state holds.
- A change of mode or sel affects only the next grant decision. A word already held in the register is never altered.
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. in_ready = 0 while rst is high.

## Timing
- Latency is 1 cycle. A word accepted on edge k appears on out_data after edge k.
- Throughput is one word per cycle when out_ready is held at 1.
- An input transfer occurs when in_valid[i] && in_ready[i] at the rising edge.
- An output transfer occurs when out_valid && out_ready at the rising edge.
- in_ready is combinational from state, in_valid, out_ready, mode and sel. It must not depend on in_data.
- Producers must hold in_valid and data stable until their transfer completes. Dropping valid early is a protocol error, but the block still tolerates it without corrupting state.
- The block must never lose or duplicate a word.
- Reset asserted mid-transfer discards the held word. out_valid falls immediately, without waiting for a clock edge.

## Structure
- Shared package/include stream_mux_pkg holds MODE_RR = 1'b0 and MODE_FIXED = 1'b1.
- Sub-module rr_arbiter (parameter N) is combinational:
  - inputs: req [N-1:0], ptr [SW-1:0]
  - outputs: gnt [N-1:0] one-hot, gnt_idx [SW-1:0], any_gnt
- The top level contains the mode mux for the grant, the output register, the pointer register and the in_ready decode.

## Test plan
Configuration for all scenarios: N = 4, W = 8; channel i data = 8'hA0+i.
- **Reset:** rst = 1 with all in_valid set → out_valid = 0, out_data = 8'h00, out_ch = 0, in_ready = 4'b0000. Asserting rst between edges drops out_valid immediately.
- **Round-robin fairness:** mode 0, in_valid = 4'b1111, out_ready = 1 → out_data A0, A1, A2, A3, A0 on consecutive cycles; out_ch 0, 1, 2, 3, 0.
- **Backpressure:** out_ready = 0 once A0 is held → out_data stays A0 and in_ready = 4'b0000. Releasing out_ready yields A1 next, with no loss or duplicate.
- **Sparse wrap-around:** mode 0, ptr = 1, in_valid = 4'b1001 → grants go to ch3, ch0, ch3, ch0.
- **Fixed mode, sel = 2:** mode 1, in_valid = 4'b1111 → only ch2 drains, with in_ready = 4'b0100.
- **Fixed mode, sel = 3 idle:** sel = 3 with in_valid[3] = 0 → out_valid = 0 after the next edge.
- **Mode switch:** switch from mode 1 to mode 0 while a word is held → the held word is unchanged; arbitration resumes from the pointer value saved before fixed mode.
